alu_seq: RTL and testbench

//   Handshaked, parametrised integer ALU that replaces the single-cycle combinational ALU.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_mul_iter.sv | 37 +++
 rtl/alu_seq.sv | 89 ++++++++
 tb/tb_alu_seq.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and shift-amount width helper for alu_seq
package alu_pkg;
  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_AND  = 2;
  localparam int OP_OR   = 3;
  localparam int OP_SRL  = 4;
  localparam int OP_SRA  = 5;
  localparam int OP_SLL  = 6;
  localparam int OP_SLT  = 7;
  localparam int OP_SLTU = 8;
  localparam int OP_MUL  = 9;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int shamt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle for alu_seq
//   master (source/sink side): drives in_valid, a, b, op, out_ready
//   slave  (ALU side):         drives in_ready, out_valid, c, busy (+ zero, ovf with ALU_FLAGS_EN)
interface alu_seq_if #(parameter int WIDTH = 32, parameter int OPW = 4);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             busy;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             ovf;
  modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, c, busy, zero, ovf);
  modport slave  (input in_valid, a, b, op, out_ready, output in_ready, out_valid, c, busy, zero, ovf);
`else
  modport master (output in_valid, a, b, op, out_ready, input in_ready, out_valid, c, busy);
  modport slave  (input in_valid, a, b, op, out_ready, output in_ready, out_valid, c, busy);
`endif
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per clock, LSB first
//   i_start loads operands and clears acc/cnt; i_en advances one step
//   o_p is the accumulator including the current step, o_done marks the last step
module alu_mul_iter import alu_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_p
);
  localparam int CW = shamt_w(WIDTH);
  logic [WIDTH-1:0] r_acc, r_mcand, r_mplier;
  logic [CW-1:0]    r_cnt;
  assign o_p    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done = i_en && (r_cnt == CW'(WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= '0;
    end else if (i_en) begin
      r_acc    <= o_p;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU, single-cycle ops in 1 clk, MUL iterative in WIDTH clks
//   clk, rst_n (async active-low); ifc (alu_seq_if.slave): in_valid/in_ready/a/b/op,
//   out_valid/out_ready/c, busy; zero/ovf flags only when ALU_FLAGS_EN is defined
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    ifc
);
  localparam int SW = shamt_w(WIDTH);
  localparam int M  = WIDTH - 1;
  state_t           r_state, w_next;
  logic [OPW-1:0]   w_op;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_add, w_sub, w_res, w_prod, w_cv, r_c;
  logic             w_accept, w_is_mul, w_mul_done, w_load;
  assign w_op     = ifc.op;
  assign w_sh     = ifc.b[SW-1:0];
  assign w_add    = ifc.a + ifc.b;
  assign w_sub    = ifc.a - ifc.b;
  assign w_is_mul = 32'(w_op) == OP_MUL;
  assign w_accept = ifc.in_valid && ifc.in_ready;
  assign ifc.in_ready  = (r_state == ST_IDLE) || (r_state == ST_DONE && ifc.out_ready);
  assign ifc.out_valid = r_state == ST_DONE;
  assign ifc.busy      = r_state == ST_CALC;
  assign ifc.c         = r_c;
  always_comb begin
    w_res = '0;
    case (32'(w_op))
      OP_ADD:  w_res = w_add;
      OP_SUB:  w_res = w_sub;
      OP_AND:  w_res = ifc.a & ifc.b;
      OP_OR:   w_res = ifc.a | ifc.b;
      OP_SRL:  w_res = ifc.a >> w_sh;
      OP_SRA:  w_res = WIDTH'($signed(ifc.a) >>> w_sh);
      OP_SLL:  w_res = ifc.a << w_sh;
      OP_SLT:  w_res = WIDTH'($signed(ifc.a) < $signed(ifc.b));
      OP_SLTU: w_res = WIDTH'(ifc.a < ifc.b);
      default: w_res = '0;
    endcase
  end
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_mul),
    .i_en    (r_state == ST_CALC),
    .i_a     (ifc.a),
    .i_b     (ifc.b),
    .o_done  (w_mul_done),
    .o_p     (w_prod)
  );
  // accept and mul completion are mutually exclusive (IDLE/DONE vs CALC)
  assign w_load = (w_accept && !w_is_mul) || w_mul_done;
  assign w_cv   = w_mul_done ? w_prod : w_res;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = w_is_mul ? ST_CALC : ST_DONE;
    else if (r_state == ST_CALC) w_next = w_mul_done ? ST_DONE : ST_CALC;
    else if (r_state == ST_DONE && !ifc.out_ready) w_next = ST_DONE;
    else w_next = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) r_c <= w_cv;
    end
  end
`ifdef ALU_FLAGS_EN
  logic w_ovf, r_zero, r_ovf;
  assign w_ovf = (32'(w_op) == OP_ADD) ? (ifc.a[M] == ifc.b[M]) && (w_add[M] != ifc.a[M]) :
                 (32'(w_op) == OP_SUB) ? (ifc.a[M] != ifc.b[M]) && (w_sub[M] != ifc.a[M]) : 1'b0;
  assign ifc.zero = r_zero;
  assign ifc.ovf  = r_ovf;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_load) begin
      r_zero <= w_cv == '0;
      r_ovf  <= !w_mul_done && w_ovf;
    end
  end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq with a result scoreboard
module tb_alu_seq;
  import alu_pkg::*;
  localparam int W = 32;
  typedef struct packed {
    logic [W-1:0] c;
    logic         zero;
    logic         ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_seq_if #(.WIDTH(W), .OPW(4)) ifc ();
  alu_seq #(.WIDTH(W), .OPW(4)) dut (.clk(clk), .rst_n(rst_n), .ifc(ifc));
  exp_t sb[$];
  exp_t e_mon;
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint s;
    e = '0;
    case (int'(op))
      OP_ADD: begin
        e.c = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = s != longint'($signed(e.c));
      end
      OP_SUB: begin
        e.c = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = s != longint'($signed(e.c));
      end
      OP_AND:  e.c = a & b;
      OP_OR:   e.c = a | b;
      OP_SRL:  e.c = a >> (b % W);
      OP_SRA:  e.c = $signed(a) >>> (b % W);
      OP_SLL:  e.c = a << (b % W);
      OP_SLT:  e.c = ($signed(a) < $signed(b)) ? 1 : 0;
      OP_SLTU: e.c = (a < b) ? 1 : 0;
      OP_MUL:  e.c = a * b;
      default: e.c = '0;
    endcase
    e.zero = e.c == '0;
    return e;
  endfunction

  task automatic present(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ifc.in_valid = 1'b1;
    ifc.op = op;
    ifc.a = a;
    ifc.b = b;
    sb.push_back(model(op, a, b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    present(op, a, b);
    while (!ifc.in_ready && n < 200) begin
      step();
      n++;
    end
    chk("accept_timeout", 64'(n < 200), 1);
    step();
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 1);
      else begin
        e_mon = sb.pop_front();
        chk("c", ifc.c, e_mon.c);
`ifdef ALU_FLAGS_EN
        chk("zero", ifc.zero, e_mon.zero);
        chk("ovf", ifc.ovf, e_mon.ovf);
`endif
      end
    end
  end

  initial begin
    int n;
    logic bad, seen;
    ifc.in_valid = 1'b1;
    ifc.op = 4'(OP_ADD);
    ifc.a = 1;
    ifc.b = 1;
    ifc.out_ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_in_ready", ifc.in_ready, 1);
    chk("rst_out_valid", ifc.out_valid, 0);
    chk("rst_c", ifc.c, 0);
    chk("rst_busy", ifc.busy, 0);
    step();
    ifc.in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_out_valid", ifc.out_valid, 0);
    step();
    ifc.out_ready = 1'b1;
    send(4'(OP_ADD), 32'h7FFF_FFFF, 32'd1);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("add_latency", ifc.out_valid, 1);
    step();
    send(4'(OP_SRA), 32'h8000_0000, 32'd33);
    send(4'(OP_SRL), 32'h8000_0000, 32'd33);
    send(4'(OP_SLL), 32'd1, 32'd35);
    send(4'(OP_SLT), 32'hFFFF_FFFF, 32'd1);
    send(4'(OP_SLTU), 32'hFFFF_FFFF, 32'd1);
    send(4'(OP_AND), 32'hF0F0_1234, 32'h0FF0_FF00);
    send(4'(OP_OR), 32'hF000_0001, 32'h0000_1230);
    send(4'(OP_SUB), 32'd3, 32'd5);
    send(4'(OP_SUB), 32'h8000_0000, 32'd1);
    send(4'd12, 32'd99, 32'd1);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    step();
    send(4'(OP_MUL), 32'd7, 32'hFFFF_FFFF);
    present(4'(OP_ADD), 32'd1, 32'd2);
    n = 0;
    bad = 1'b0;
    @(negedge clk);
    while (ifc.busy && n < 100) begin
      if (ifc.in_ready) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    chk("mul_busy_clks", 64'(n), 32);
    chk("mul_ready_low", bad, 0);
    chk("mul_out_valid", ifc.out_valid, 1);
    chk("mul_done_ready", ifc.in_ready, 1);
    step();
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("after_mul_valid", ifc.out_valid, 1);
    step();
    ifc.out_ready = 1'b0;
    send(4'(OP_SUB), 32'd5, 32'd5);
    ifc.in_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("hold_valid", ifc.out_valid, 1);
      chk("hold_c", ifc.c, 0);
      chk("hold_in_ready", ifc.in_ready, 0);
`ifdef ALU_FLAGS_EN
      chk("hold_zero", ifc.zero, 1);
`endif
    end
    step();
    present(4'(OP_ADD), 32'd10, 32'd20);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", ifc.in_ready, 1);
    step();
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble", ifc.out_valid, 1);
    step();
    send(4'(OP_MUL), 32'd3, 32'd4);
    ifc.in_valid = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_out_valid", ifc.out_valid, 0);
    chk("abort_c", ifc.c, 0);
    chk("abort_busy", ifc.busy, 0);
    chk("abort_in_ready", ifc.in_ready, 1);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.out_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    step();
    send(4'(OP_ADD), 32'd2, 32'd3);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("post_abort_valid", ifc.out_valid, 1);
    step();
    step();
    chk("sb_empty", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
